set_bit_walker: RTL and testbench

SET_BIT_WALKER -- requirements
Module: set_bit_walker

---
 rtl/set_bit_walker.sv | 134 +++++++++++++
 tb/tb_set_bit_walker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_walker.sv
// Enumerates the set bits of a vector MSB-first by iterating an external find-first-set stage.
// Optional SET_BIT_WALKER_COUNT_EN adds a done_count output with the number of indices emitted.
module set_bit_walker #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_vector,
   output logic             ffs_vld,
   output logic [WIDTH-1:0] ffs_vector,
   input  logic             ffs_out_vld,
   input  logic [15:0]      ffs_location,
   output logic             bit_vld,
   input  logic             bit_rdy,
   output logic [15:0]      bit_index,
   output logic             bit_last,
`ifdef SET_BIT_WALKER_COUNT_EN
   output logic [15:0]      done_count,
`endif
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      PRESENT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] residual_q, residual_d;
   logic [15:0]      bit_index_q, bit_index_d;
   logic             bit_last_q, bit_last_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] clear_mask;
   logic [WIDTH-1:0] residual_cleared;

   // Out-of-range locations match no bit, so the residual is left untouched.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_clear
      assign clear_mask[gi] = (ffs_location == 16'(gi));
   end
   assign residual_cleared = residual_q & ~clear_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         residual_q  <= '0;
         bit_index_q <= '0;
         bit_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         residual_q  <= residual_d;
         bit_index_q <= bit_index_d;
         bit_last_q  <= bit_last_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      residual_d  = residual_q;
      bit_index_d = bit_index_q;
      bit_last_d  = bit_last_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_vld) begin
               if (|in_vector) begin
                  residual_d = in_vector;
                  state_d    = ISSUE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (ffs_out_vld) begin
               bit_index_d = ffs_location;
               residual_d  = residual_cleared;
               bit_last_d  = ~|residual_cleared;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            if (bit_rdy) begin
               if (bit_last_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_rdy     = (state_q == IDLE);
   assign ffs_vld    = (state_q == ISSUE);
   assign ffs_vector = residual_q;
   assign bit_vld    = (state_q == PRESENT);
   assign bit_index  = bit_index_q;
   assign bit_last   = bit_last_q;
   assign done       = done_q;

`ifdef SET_BIT_WALKER_COUNT_EN
   logic [15:0] count_q, count_d;

   // Cleared on every acceptance; still holds the final tally during the done pulse.
   always_comb begin
      count_d = count_q;
      if (state_q == IDLE && in_vld) begin
         count_d = '0;
      end else if (state_q == PRESENT && bit_rdy) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_count = count_q;
`endif

endmodule

// File: tb/tb_set_bit_walker.sv
// Directed bench for set_bit_walker with a behavioural find-first-set stage.
// Build with SET_BIT_WALKER_COUNT_EN defined to also check done_count.
module tb_set_bit_walker;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_vld;
   logic             in_rdy;
   logic [WIDTH-1:0] in_vector;
   logic             ffs_vld;
   logic [WIDTH-1:0] ffs_vector;
   logic             ffs_out_vld;
   logic [15:0]      ffs_location;
   logic             bit_vld;
   logic             bit_rdy;
   logic [15:0]      bit_index;
   logic             bit_last;
   logic             done;
`ifdef SET_BIT_WALKER_COUNT_EN
   logic [15:0]      done_count;
`endif

   logic             force_en;
   logic [15:0]      force_loc;
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   set_bit_walker #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .in_vector    (in_vector),
      .ffs_vld      (ffs_vld),
      .ffs_vector   (ffs_vector),
      .ffs_out_vld  (ffs_out_vld),
      .ffs_location (ffs_location),
      .bit_vld      (bit_vld),
      .bit_rdy      (bit_rdy),
      .bit_index    (bit_index),
      .bit_last     (bit_last),
`ifdef SET_BIT_WALKER_COUNT_EN
      .done_count   (done_count),
`endif
      .done         (done)
   );

   function automatic logic [15:0] msb_of(input logic [WIDTH-1:0] v);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) r = 16'(i);
      end
      return r;
   endfunction

   // Find-first-set stage: answers one cycle after each request; can be forced to a given location.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ffs_out_vld  <= 1'b0;
         ffs_location <= '0;
      end else begin
         ffs_out_vld  <= ffs_vld;
         ffs_location <= force_en ? force_loc : msb_of(ffs_vector);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the accept or handshake cycle; ends in the PRESENT cycle of the next index.
   task automatic expect_bit(input logic [WIDTH-1:0] res, input logic [15:0] idx, input logic last);
      tick();
      in_vld = 1'b0;
      chk("issue_vld", 32'(ffs_vld), 32'd1);
      chk("issue_vec", 32'(ffs_vector), 32'(res));
      chk("issue_rdy", 32'(in_rdy), 32'd0);
      chk("issue_bvld", 32'(bit_vld), 32'd0);
      tick();
      chk("wait_bvld", 32'(bit_vld), 32'd0);
      chk("wait_fvld", 32'(ffs_vld), 32'd0);
      tick();
      chk("pres_vld", 32'(bit_vld), 32'd1);
      chk("pres_idx", 32'(bit_index), 32'(idx));
      chk("pres_last", 32'(bit_last), 32'(last));
      $display("bit res=%02h idx=%0d last=%0b", res, bit_index, bit_last);
   endtask

   task automatic expect_done(input logic [15:0] cnt);
      tick();
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_rdy", 32'(in_rdy), 32'd1);
      chk("done_bvld", 32'(bit_vld), 32'd0);
`ifdef SET_BIT_WALKER_COUNT_EN
      chk("done_count", 32'(done_count), 32'(cnt));
`else
      if (cnt == 16'hFFFF) $display("unexpected count marker");
`endif
      $display("done count_exp=%0d", cnt);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_vld    = 1'b0;
      in_vector = '0;
      bit_rdy   = 1'b1;
      force_en  = 1'b0;
      force_loc = '0;
      #3;
      chk("rst_rdy", 32'(in_rdy), 32'd1);
      chk("rst_fvld", 32'(ffs_vld), 32'd0);
      chk("rst_fvec", 32'(ffs_vector), 32'd0);
      chk("rst_bvld", 32'(bit_vld), 32'd0);
      chk("rst_idx", 32'(bit_index), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 8'hA1 -> 7,5,0
      in_vld = 1'b1; in_vector = 8'hA1;
      expect_bit(8'hA1, 16'd7, 1'b0);
      expect_bit(8'h21, 16'd5, 1'b0);
      expect_bit(8'h01, 16'd0, 1'b1);
      expect_done(16'd3);
      tick();
      chk("done_once", 32'(done), 32'd0);

      // zero vector
      in_vld = 1'b1; in_vector = 8'h00;
      tick();
      in_vld = 1'b0;
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_rdy", 32'(in_rdy), 32'd1);
      chk("zero_bvld", 32'(bit_vld), 32'd0);
`ifdef SET_BIT_WALKER_COUNT_EN
      chk("zero_count", 32'(done_count), 32'd0);
`endif
      $display("zero vector done=%0b", done);
      tick();
      chk("zero_bvld2", 32'(bit_vld), 32'd0);
      chk("zero_done2", 32'(done), 32'd0);

      // 8'h80 with downstream stalled for 5 cycles
      bit_rdy = 1'b0;
      in_vld = 1'b1; in_vector = 8'h80;
      expect_bit(8'h80, 16'd7, 1'b1);
      for (int i = 0; i < 4; i++) begin
         in_vld = 1'b1; in_vector = 8'hFF;
         tick();
         chk("stall_vld", 32'(bit_vld), 32'd1);
         chk("stall_idx", 32'(bit_index), 32'd7);
         chk("stall_last", 32'(bit_last), 32'd1);
         chk("stall_done", 32'(done), 32'd0);
         $display("stall cycle %0d idx=%0d", i + 2, bit_index);
      end
      in_vld = 1'b0;
      bit_rdy = 1'b1;
      expect_done(16'd1);

      // 8'hFF with reset after the second handshake
      in_vld = 1'b1; in_vector = 8'hFF;
      expect_bit(8'hFF, 16'd7, 1'b0);
      expect_bit(8'h7F, 16'd6, 1'b0);
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_fvld", 32'(ffs_vld), 32'd0);
      chk("mrst_fvec", 32'(ffs_vector), 32'd0);
      chk("mrst_bvld", 32'(bit_vld), 32'd0);
      chk("mrst_idx", 32'(bit_index), 32'd0);
      chk("mrst_last", 32'(bit_last), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      $display("reset mid-enumeration");
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_bvld", 32'(bit_vld), 32'd0);
         chk("post_done", 32'(done), 32'd0);
         chk("post_rdy", 32'(in_rdy), 32'd1);
      end
      in_vld = 1'b1; in_vector = 8'h02;
      expect_bit(8'h02, 16'd1, 1'b1);
      expect_done(16'd1);
      tick();

      // back-to-back 8'h03 then 8'h40
      in_vld = 1'b1; in_vector = 8'h03;
      expect_bit(8'h03, 16'd1, 1'b0);
      expect_bit(8'h01, 16'd0, 1'b1);
      expect_done(16'd2);
      in_vld = 1'b1; in_vector = 8'h40;
      expect_bit(8'h40, 16'd6, 1'b1);
      expect_done(16'd1);
      tick();

      // bogus locations: out of range, then a clear bit
      force_en = 1'b1; force_loc = 16'd9;
      in_vld = 1'b1; in_vector = 8'h05;
      expect_bit(8'h05, 16'd9, 1'b0);
      force_loc = 16'd1;
      expect_bit(8'h05, 16'd1, 1'b0);
      force_en = 1'b0;
      expect_bit(8'h05, 16'd2, 1'b0);
      expect_bit(8'h01, 16'd0, 1'b1);
      expect_done(16'd4);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
